// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving an external call stack: NEXT/JMP/CALL/RET/RETI
// plus single-level interrupt entry, with a sticky fault that halts until reset.
module pc_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [11:0] IRQ_VECTOR = 12'h004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [2:0]  op,
  input  logic [11:0] target,
  input  logic        irq,
  input  logic [11:0] stk_q,
  output logic [11:0] pc,
  output logic        stk_enable,
  output logic        stk_w_enable,
  output logic [11:0] stk_data,
  output logic [3:0]  depth,
  output logic        in_isr,
  output logic        irq_ack,
  output logic        fault
);

  typedef enum logic {RUN, HALT} state_t;
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0, OP_JMP = 3'd1, OP_CALL = 3'd2, OP_RET = 3'd3, OP_RETI = 3'd4
  } op_t;

  localparam logic [3:0] LP_DEPTH = 4'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [11:0] r_pc, w_pc_nxt;
  logic [3:0]  r_depth, w_depth_nxt;
  logic        r_in_isr, w_isr_nxt;
  logic        r_irq_ack, w_ack_nxt;
  logic        r_fault, w_fault_ev;
  logic        w_stk_en, w_stk_we;
  logic [11:0] w_stk_data;
  logic        w_active;
  op_t         w_op;

  assign w_op     = op_t'(op);
  assign w_active = !reset && (r_state == RUN) && step;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_isr_nxt   = r_in_isr;
    w_ack_nxt   = 1'b0;
    w_fault_ev  = 1'b0;
    w_stk_en    = 1'b0;
    w_stk_we    = 1'b0;
    w_stk_data  = '0;
    if (w_active) begin
      if (irq && !r_in_isr) begin
        // Interrupt wins over op; the op of this cycle is dropped.
        if (r_depth < LP_DEPTH) begin
          w_stk_en    = 1'b1;
          w_stk_we    = 1'b1;
          w_stk_data  = r_pc;
          w_pc_nxt    = IRQ_VECTOR;
          w_depth_nxt = r_depth + 4'd1;
          w_isr_nxt   = 1'b1;
          w_ack_nxt   = 1'b1;
        end else begin
          w_fault_ev = 1'b1;
        end
      end else begin
        case (w_op)
          OP_JMP: w_pc_nxt = target;
          OP_CALL: begin
            if (r_depth < LP_DEPTH) begin
              w_stk_en    = 1'b1;
              w_stk_we    = 1'b1;
              w_stk_data  = r_pc + 12'd1;
              w_pc_nxt    = target;
              w_depth_nxt = r_depth + 4'd1;
            end else begin
              w_fault_ev = 1'b1;
            end
          end
          OP_RET: begin
            if (r_depth != 4'd0) begin
              w_stk_en    = 1'b1;
              w_pc_nxt    = stk_q;
              w_depth_nxt = r_depth - 4'd1;
            end else begin
              w_fault_ev = 1'b1;
            end
          end
          OP_RETI: begin
            if (r_in_isr && (r_depth != 4'd0)) begin
              w_stk_en    = 1'b1;
              w_pc_nxt    = stk_q;
              w_depth_nxt = r_depth - 4'd1;
              w_isr_nxt   = 1'b0;
            end else begin
              w_fault_ev = 1'b1;
            end
          end
          default: w_pc_nxt = r_pc + 12'd1;
        endcase
      end
    end
    if (w_fault_ev) w_state_nxt = HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_pc      <= '0;
      r_depth   <= '0;
      r_in_isr  <= 1'b0;
      r_irq_ack <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_depth   <= w_depth_nxt;
      r_in_isr  <= w_isr_nxt;
      r_irq_ack <= w_ack_nxt;
      r_fault   <= r_fault | w_fault_ev;
    end
  end

  assign pc           = r_pc;
  assign depth        = r_depth;
  assign in_isr       = r_in_isr;
  assign irq_ack      = r_irq_ack;
  assign fault        = r_fault;
  assign stk_enable   = w_stk_en;
  assign stk_w_enable = w_stk_we;
  assign stk_data     = w_stk_data;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random ops, checked against a
// queue-based model that also plays the role of the attached call stack.
module tb_pc_sequencer;

  localparam int unsigned DEPTH      = 8;
  localparam logic [11:0] IRQ_VECTOR = 12'h004;

  logic        clk = 1'b0;
  logic        reset, step, irq;
  logic [2:0]  op;
  logic [11:0] target, stk_q;
  logic [11:0] pc, stk_data;
  logic        stk_enable, stk_w_enable, in_isr, irq_ack, fault;
  logic [3:0]  depth;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the queue is the stack itself, its size is the depth.
  logic [11:0] m_stack[$];
  int          m_pc    = 0;
  bit          m_isr   = 0;
  bit          m_ack   = 0;
  bit          m_fault = 0;

  pc_sequencer #(.DEPTH(DEPTH), .IRQ_VECTOR(IRQ_VECTOR)) dut (
    .clk(clk), .reset(reset), .step(step), .op(op), .target(target), .irq(irq),
    .stk_q(stk_q), .pc(pc), .stk_enable(stk_enable), .stk_w_enable(stk_w_enable),
    .stk_data(stk_data), .depth(depth), .in_isr(in_isr), .irq_ack(irq_ack),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check strobes, advance model, check registers.
  task automatic apply(input bit rst, input bit stp, input logic [2:0] o,
                       input logic [11:0] tg, input bit iq);
    bit e_en, e_we;
    int e_data;
    bit entry;
    reset = rst; step = stp; op = o; target = tg; irq = iq;
    stk_q = (m_stack.size() > 0) ? m_stack[$] : 12'($urandom);
    e_en = 0; e_we = 0; e_data = 0;
    entry = iq && !m_isr;
    if (!rst && !m_fault && stp) begin
      if (entry) begin
        if (m_stack.size() < DEPTH) begin e_en = 1; e_we = 1; e_data = m_pc; end
      end else if (o == 3'd2) begin
        if (m_stack.size() < DEPTH) begin e_en = 1; e_we = 1; e_data = (m_pc + 1) % 4096; end
      end else if (o == 3'd3) begin
        e_en = (m_stack.size() > 0);
      end else if (o == 3'd4) begin
        e_en = m_isr && (m_stack.size() > 0);
      end
    end
    #1;
    chk("stk_enable", 32'(stk_enable), 32'(e_en));
    chk("stk_w_enable", 32'(stk_w_enable), 32'(e_we));
    chk("stk_data", 32'(stk_data), 32'(e_data));
    @(posedge clk);
    if (rst) begin
      m_stack.delete(); m_pc = 0; m_isr = 0; m_ack = 0; m_fault = 0;
    end else begin
      m_ack = 0;
      if (!m_fault && stp) begin
        if (entry) begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back(12'(m_pc)); m_pc = IRQ_VECTOR; m_isr = 1; m_ack = 1;
          end else m_fault = 1;
        end else begin
          case (o)
            3'd1: m_pc = tg;
            3'd2: if (m_stack.size() < DEPTH) begin
                    m_stack.push_back(12'((m_pc + 1) % 4096)); m_pc = tg;
                  end else m_fault = 1;
            3'd3: if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                  else m_fault = 1;
            3'd4: if (m_isr && m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back(); m_isr = 0;
                  end else m_fault = 1;
            default: m_pc = (m_pc + 1) % 4096;
          endcase
        end
      end
    end
    @(negedge clk);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("depth", 32'(depth), 32'(m_stack.size()));
    chk("in_isr", 32'(in_isr), 32'(m_isr));
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; op = '0; target = '0; irq = 1'b0; stk_q = '0;
    @(negedge clk);

    // Reset then NEXT x3, JMP FFF, NEXT wraps
    apply(1, 0, 0, 0, 0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0);
    chk("next3_pc", 32'(pc), 32'h3);
    apply(0, 1, 1, 12'hFFF, 0);
    apply(0, 1, 0, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h0);

    // CALL/RET round trip
    apply(0, 1, 1, 12'h010, 0);
    apply(0, 1, 2, 12'h100, 0);
    chk("call_pc", 32'(pc), 32'h100);
    chk("call_top", 32'(m_stack[$]), 32'h011);
    apply(0, 1, 3, 0, 0);
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_depth", 32'(depth), 32'h0);

    // Overflow
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, 1, 2, 12'(12'h200 + i), 0);
    chk("full_depth", 32'(depth), 32'd8);
    apply(0, 1, 2, 12'h300, 0);
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_pc", 32'(pc), 32'h207);
    apply(0, 1, 1, 12'h555, 1);
    chk("halt_pc", 32'(pc), 32'h207);

    // Underflow and illegal RETI
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 3, 0, 0);
    chk("unf_fault", 32'(fault), 32'h1);
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 4, 0, 0);
    chk("reti_fault", 32'(fault), 32'h1);

    // Interrupt entry beats CALL, no nesting, RETI returns
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 1, 12'h020, 0);
    apply(0, 1, 2, 12'h300, 1);
    chk("irq_pc", 32'(pc), 32'h004);
    chk("irq_ack", 32'(irq_ack), 32'h1);
    chk("irq_top", 32'(m_stack[$]), 32'h020);
    apply(0, 1, 0, 0, 1);
    chk("nonest_pc", 32'(pc), 32'h005);
    chk("ack_pulse", 32'(irq_ack), 32'h0);
    apply(0, 1, 4, 0, 0);
    chk("reti_pc", 32'(pc), 32'h020);
    chk("reti_isr", 32'(in_isr), 32'h0);

    // Reset overrides a CALL at depth 3
    for (int i = 0; i < 3; i++) apply(0, 1, 2, 12'h040, 0);
    apply(1, 1, 2, 12'h400, 1);
    chk("rstcall_depth", 32'(depth), 32'h0);
    chk("rstcall_pc", 32'(pc), 32'h0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      logic [2:0] o;
      bit rst;
      r = $urandom_range(0, 9);
      if (r <= 1) o = 3'd0;
      else if (r == 2) o = 3'd1;
      else if (r <= 5) o = 3'd2;
      else if (r <= 7) o = 3'd3;
      else if (r == 8) o = 3'd4;
      else o = 3'($urandom_range(5, 7));
      rst = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      apply(rst, $urandom_range(0, 3) != 0, o, 12'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
